// File: rtl/conv_relu_pool.sv
// conv_relu_pool: post-processing stage after the 7x7 convolution core.
// Takes a raster-order signed accumulator stream and applies ReLU. It then
// requantises to OUT_W-bit unsigned with rounding and saturation, and finally
// does 2x2 stride-2 max pooling. Framing strobes are regenerated for the
// pooled frame.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid, in_data               accumulator stream (signed ACC_W)
//   in_frame_start, in_frame_end    framing, qualified by in_valid
//   out_valid, out_data             pooled pixel, one-cycle pulse
//   frame_start_out, line_start_out, frame_end_out
//                                   pooled framing, coincident with out_valid
//   frame_err                       (CONV_RELU_POOL_ERR_EN only) sticky
//                                   framing-error flag
//
// Optional feature macro: CONV_RELU_POOL_ERR_EN adds the frame_err port.
// Latency: pixel accepted at cycle t -> pooled output at cycle t+2.
module conv_relu_pool #(
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 6,
  parameter int IN_COLS = 26,
  parameter int IN_ROWS = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic                    in_frame_start,
  input  logic                    in_frame_end,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    frame_start_out,
  output logic                    line_start_out,
  output logic                    frame_end_out
`ifdef CONV_RELU_POOL_ERR_EN
  ,
  output logic                    frame_err
`endif
);

  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam int BD = IN_COLS / 2;

  localparam logic [CW-1:0] COL_LAST  = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN_ROWS - 1);
  localparam logic [CW-2:0] PCOL_LAST = (CW-1)'(IN_COLS / 2 - 1);
  localparam logic [RW-2:0] PROW_LAST = (RW-1)'(IN_ROWS / 2 - 1);
  localparam logic [ACC_W:0] RND      = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] MAXV     = (ACC_W+1)'((1 << OUT_W) - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_cnt_q, col_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;

  logic              accept, last_pix, early_end;
  logic [CW-1:0]     pix_col;
  logic [RW-1:0]     pix_row;

  // stage 1: quantised pixel with position tags
  logic              s1_vld_q, s1_vld_d;
  logic [OUT_W-1:0]  s1_q_q, s1_q_d;
  logic [CW-1:0]     s1_col_q, s1_col_d;
  logic [RW-1:0]     s1_row_q, s1_row_d;
  logic [ACC_W:0]    rnd_sum, q_wide;

  // stage 2: horizontal pair max, row buffer, output registers
  logic [OUT_W-1:0]  h_hold_q, h_hold_d;
  logic [OUT_W-1:0]  rowbuf_q [BD];
  logic [OUT_W-1:0]  h, rb_rd;
  logic              rb_we;
  logic [CW-2:0]     pcol;
  logic [RW-2:0]     prow;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              fs_q, fs_d, ls_q, ls_d, fe_q, fe_d;

  // ---------------- input framing FSM ----------------
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    accept    = 1'b0;
    pix_col   = col_cnt_q;
    pix_row   = row_cnt_q;
    // in_frame_start always wins: it both starts from IDLE and restarts
    // a frame in progress, and the pixel is placed at (0,0).
    if (in_valid) begin
      if (in_frame_start) begin
        accept  = 1'b1;
        pix_col = '0;
        pix_row = '0;
      end else if (state_q == ACTIVE) begin
        accept = 1'b1;
      end
    end
    last_pix  = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    early_end = accept && in_frame_end && !last_pix;
    if (accept) begin
      if (last_pix || in_frame_end) begin
        state_d   = IDLE;
        col_cnt_d = '0;
        row_cnt_d = '0;
      end else begin
        state_d = ACTIVE;
        if (pix_col == COL_LAST) begin
          col_cnt_d = '0;
          row_cnt_d = pix_row + 1'b1;
        end else begin
          col_cnt_d = pix_col + 1'b1;
          row_cnt_d = pix_row;
        end
      end
    end
  end

  // ---------------- stage 1: ReLU + round + saturate ----------------
  always_comb begin
    // one extra bit keeps the rounding add from overflowing
    rnd_sum  = {1'b0, in_data} + RND;
    q_wide   = rnd_sum >> SHIFT;
    s1_vld_d = accept;
    s1_col_d = pix_col;
    s1_row_d = pix_row;
    if (in_data[ACC_W-1])    s1_q_d = '0;
    else if (q_wide > MAXV)  s1_q_d = '1;
    else                     s1_q_d = q_wide[OUT_W-1:0];
  end

  // ---------------- stage 2: 2x2 max pool ----------------
  assign pcol  = s1_col_q[CW-1:1];
  assign prow  = s1_row_q[RW-1:1];
  assign h     = (s1_q_q > h_hold_q) ? s1_q_q : h_hold_q;
  assign rb_rd = rowbuf_q[pcol];

  always_comb begin
    h_hold_d    = h_hold_q;
    rb_we       = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    fs_d        = 1'b0;
    ls_d        = 1'b0;
    fe_d        = 1'b0;
    if (s1_vld_q) begin
      if (!s1_col_q[0]) begin
        h_hold_d = s1_q_q;
      end else if (!s1_row_q[0]) begin
        // top half of the window: park the pair max for the next row
        rb_we = 1'b1;
      end else begin
        // Only odd rows and odd columns reach here, so a trailing odd
        // row or column never emits.
        out_valid_d = 1'b1;
        out_data_d  = (rb_rd > h) ? rb_rd : h;
        ls_d        = (pcol == '0);
        fs_d        = (pcol == '0) && (prow == '0);
        fe_d        = (pcol == PCOL_LAST) && (prow == PROW_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_q_q      <= '0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      h_hold_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fs_q        <= 1'b0;
      ls_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_q_q      <= s1_q_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      h_hold_q    <= h_hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      fs_q        <= fs_d;
      ls_q        <= ls_d;
      fe_q        <= fe_d;
    end
  end

  // Row buffer is not reset: each entry is written on an even row before
  // the following odd row reads it.
  always_ff @(posedge clk) begin
    if (rb_we) rowbuf_q[pcol] <= h;
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign frame_start_out = fs_q;
  assign line_start_out  = ls_q;
  assign frame_end_out   = fe_q;

`ifdef CONV_RELU_POOL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (in_valid && in_frame_start && (state_q == ACTIVE))
          | early_end
          | (in_valid && !in_frame_start && (state_q == IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_conv_relu_pool.sv
// Self-checking bench for conv_relu_pool. A frame-level reference model keeps
// a 2-D array of quantised pixels and predicts every pooled pulse (value,
// strobes, cycle). A negedge monitor compares each DUT pulse against it.
module tb_conv_relu_pool;
  localparam int ACC_W   = 20;
  localparam int OUT_W   = 8;
  localparam int SHIFT   = 6;
  localparam int IN_COLS = 26;
  localparam int IN_ROWS = 26;
  localparam int NPIX    = IN_COLS * IN_ROWS;
  localparam int NPOOL   = (IN_COLS / 2) * (IN_ROWS / 2);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [ACC_W-1:0] in_data = '0;
  logic             in_frame_start = 1'b0;
  logic             in_frame_end = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             frame_start_out, line_start_out, frame_end_out;
`ifdef CONV_RELU_POOL_ERR_EN
  logic             frame_err;
`endif

  conv_relu_pool #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
                   .IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS)) dut (
`ifdef CONV_RELU_POOL_ERR_EN
    .frame_err      (frame_err),
`endif
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_frame_start (in_frame_start),
    .in_frame_end   (in_frame_end),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .frame_start_out(frame_start_out),
    .line_start_out (line_start_out),
    .frame_end_out  (frame_end_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int               cyc;
    logic             v;
    logic [OUT_W-1:0] d;
    logic             fs;
    logic             ls;
    logic             fe;
  } ev_t;

  ev_t exp_q[$];
  int  got_d[$];
  int  n_pulse, n_fs, n_ls, n_fe, first_cyc;

  // reference model state
  bit  m_act = 1'b0;
  int  m_row, m_col;
  int  qv [IN_ROWS][IN_COLS];
  bit  exp_err = 1'b0;
  int  img [NPIX];
  int  scyc [NPIX];

  function automatic int quant(input int x);
    int v;
    if (x < 0) return 0;
    v = (x + (1 << (SHIFT - 1))) / (1 << SHIFT);
    return (v > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int rand_acc();
    if ($urandom_range(0, 1) == 1) return int'($urandom) >>> 12;
    return int'($urandom_range(0, 17000)) - 1000;
  endfunction

  // Drive one valid pixel for one cycle and advance the model.
  task automatic send(input int d, input bit fs, input bit fe);
    int  r, c;
    ev_t e;
    @(posedge clk); #1;
    in_valid       = 1'b1;
    in_data        = ACC_W'(d);
    in_frame_start = fs;
    in_frame_end   = fe;
    if (fs && m_act)  exp_err = 1'b1;
    if (!fs && !m_act) exp_err = 1'b1;
    if (fs || m_act) begin
      r = fs ? 0 : m_row;
      c = fs ? 0 : m_col;
      qv[r][c] = quant(d);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.cyc = cyc + 2;
        e.v   = 1'b1;
        e.d   = OUT_W'(max2(max2(qv[r-1][c-1], qv[r-1][c]),
                            max2(qv[r][c-1], qv[r][c])));
        e.fs  = (r == 1) && (c == 1);
        e.ls  = (c == 1);
        e.fe  = (r / 2 == IN_ROWS / 2 - 1) && (c / 2 == IN_COLS / 2 - 1);
        exp_q.push_back(e);
      end
      if (r == IN_ROWS - 1 && c == IN_COLS - 1) begin
        m_act = 1'b0;
      end else if (fe) begin
        m_act   = 1'b0;
        exp_err = 1'b1;
      end else begin
        m_act = 1'b1;
        m_row = r;
        m_col = c + 1;
        if (m_col == IN_COLS) begin
          m_col = 0;
          m_row = r + 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid       = 1'b0;
      in_frame_start = 1'b0;
      in_frame_end   = 1'b0;
      in_data        = ACC_W'($urandom);
    end
  endtask

  // mode 0: all 64; 1: random; 2: ReLU/rounding block; 3: saturation blocks
  task automatic make_img(input int mode);
    int sat [4];
    sat = '{16287, 16288, 20000, -1};
    for (int i = 0; i < NPIX; i++)
      img[i] = (mode == 0) ? 64 : (mode == 1 || mode == 3) ? rand_acc() : 0;
    if (mode == 2) begin
      img[0] = -640; img[1] = 192; img[IN_COLS] = 320; img[IN_COLS+1] = 1000;
    end
    if (mode == 3)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 8; c++) img[r*IN_COLS + c] = sat[c/2];
  endtask

  task automatic send_frame(input int gapmax, input int from, input int upto,
                            input int fe_at);
    for (int i = from; i < upto; i++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send(img[i], i == 0, i == fe_at);
      scyc[i] = cyc;
    end
  endtask

  task automatic clear_counts();
    n_pulse = 0; n_fs = 0; n_ls = 0; n_fe = 0; first_cyc = -1;
    got_d.delete();
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    ev_t o, e;
    if ((out_valid | frame_start_out | line_start_out | frame_end_out) === 1'b1) begin
      o.cyc = cyc; o.v = out_valid; o.d = out_data;
      o.fs = frame_start_out; o.ls = line_start_out; o.fe = frame_end_out;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_pulse: got cyc=%0d v=%b d=%0d fs=%b ls=%b fe=%b, required no pulse",
                 o.cyc, o.v, o.d, o.fs, o.ls, o.fe);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL out_pulse: got cyc=%0d v=%b d=%0d fs=%b ls=%b fe=%b, required cyc=%0d v=%b d=%0d fs=%b ls=%b fe=%b",
                   o.cyc, o.v, o.d, o.fs, o.ls, o.fe, e.cyc, e.v, e.d, e.fs, e.ls, e.fe);
        end
      end
      if (out_valid === 1'b1) begin
        if (n_pulse == 0) first_cyc = cyc;
        n_pulse++;
        if (frame_start_out) n_fs++;
        if (line_start_out)  n_ls++;
        if (frame_end_out)   n_fe++;
        got_d.push_back(int'(out_data));
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_act = 1'b0; exp_err = 1'b0; exp_q.delete();
    total++;
    if ({out_valid, out_data, frame_start_out, line_start_out, frame_end_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%0d fs=%b ls=%b fe=%b, required all 0",
               out_valid, out_data, frame_start_out, line_start_out, frame_end_out);
    end
`ifdef CONV_RELU_POOL_ERR_EN
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_err: got %b required 0", frame_err);
    end
`endif
  endtask

  task automatic test_full_frame();
    int ones;
    clear_counts();
    make_img(0);
    send_frame(0, 0, NPIX, NPIX - 1);
    idle(4);
    ones = 0;
    foreach (got_d[i]) if (got_d[i] == 1) ones++;
    total += 6;
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_pending: got %0d required 0", exp_q.size()); end
    if (n_pulse != NPOOL)  begin bad++; $display("FAIL full_pulses: got %0d required %0d", n_pulse, NPOOL); end
    if (first_cyc != scyc[IN_COLS+1] + 2) begin
      bad++; $display("FAIL full_first_latency: got cyc %0d required %0d", first_cyc, scyc[IN_COLS+1] + 2);
    end
    if (ones != NPOOL) begin bad++; $display("FAIL full_data: got %0d ones required %0d", ones, NPOOL); end
    if (n_ls != IN_ROWS / 2) begin bad++; $display("FAIL full_line_starts: got %0d required %0d", n_ls, IN_ROWS / 2); end
    if (n_fs != 1 || n_fe != 1) begin
      bad++; $display("FAIL full_frame_strobes: got fs=%0d fe=%0d required 1 1", n_fs, n_fe);
    end
  endtask

  task automatic test_relu_round();
    clear_counts();
    make_img(2);
    send_frame(0, 0, NPIX, NPIX - 1);
    idle(4);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL relu_pending: got %0d required 0", exp_q.size()); end
    if (got_d.size() < 1 || got_d[0] != 16) begin
      bad++; $display("FAIL relu_pool00: got %0d required 16", (got_d.size() > 0) ? got_d[0] : -1);
    end
  endtask

  task automatic test_saturation();
    int req [4];
    req = '{254, 255, 255, 0};
    clear_counts();
    make_img(3);
    send_frame(0, 0, NPIX, NPIX - 1);
    idle(4);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sat_pending: got %0d required 0", exp_q.size()); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_d.size() <= k || got_d[k] != req[k]) begin
        bad++;
        $display("FAIL sat_block%0d: got %0d required %0d", k, (got_d.size() > k) ? got_d[k] : -1, req[k]);
      end
    end
  endtask

  task automatic test_gapped();
    int ones;
    clear_counts();
    make_img(0);
    send_frame(3, 0, NPIX, NPIX - 1);
    idle(4);
    ones = 0;
    foreach (got_d[i]) if (got_d[i] == 1) ones++;
    total += 4;
    if (exp_q.size() != 0) begin bad++; $display("FAIL gap_pending: got %0d required 0", exp_q.size()); end
    if (ones != NPOOL) begin bad++; $display("FAIL gap_data: got %0d ones required %0d", ones, NPOOL); end
    if (n_ls != IN_ROWS / 2) begin bad++; $display("FAIL gap_line_starts: got %0d required %0d", n_ls, IN_ROWS / 2); end
    if (n_fs != 1 || n_fe != 1) begin
      bad++; $display("FAIL gap_frame_strobes: got fs=%0d fe=%0d required 1 1", n_fs, n_fe);
    end
  endtask

  task automatic test_random();
    clear_counts();
    make_img(1);
    send_frame(2, 0, NPIX, NPIX - 1);
    idle(4);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_pending: got %0d required 0", exp_q.size()); end
    if (n_pulse != NPOOL) begin bad++; $display("FAIL rand_pulses: got %0d required %0d", n_pulse, NPOOL); end
  endtask

  task automatic test_restart();
    clear_counts();
    make_img(1);
    send_frame(0, 0, 300, -1);
`ifdef CONV_RELU_POOL_ERR_EN
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL restart_err_before: got %b required 0", frame_err); end
`endif
    make_img(1);
    send(img[0], 1'b1, 1'b0);
    scyc[0] = cyc;
    idle(1);
`ifdef CONV_RELU_POOL_ERR_EN
    total++;
    if (frame_err !== 1'b1) begin bad++; $display("FAIL restart_err_after: got %b required 1", frame_err); end
`endif
    send_frame(0, 1, NPIX, NPIX - 1);
    idle(4);
    total += 3;
    if (exp_q.size() != 0) begin bad++; $display("FAIL restart_pending: got %0d required 0", exp_q.size()); end
    if (n_pulse != 72 + NPOOL) begin bad++; $display("FAIL restart_pulses: got %0d required %0d", n_pulse, 72 + NPOOL); end
    if (n_fe != 1 || n_fs != 2) begin
      bad++; $display("FAIL restart_strobes: got fs=%0d fe=%0d required 2 1", n_fs, n_fe);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    make_img(1);
    send_frame(0, 0, 84, 83);   // early end on pooled-position pixel (3,5)
    idle(1);
    for (int i = 0; i < 10; i++) send(rand_acc(), 1'b0, 1'b0);
    make_img(1);
    send_frame(0, 0, NPIX, NPIX - 1);
    idle(4);
    total += 3;
    if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pending: got %0d required 0", exp_q.size()); end
    if (n_pulse != 16 + NPOOL) begin bad++; $display("FAIL abort_pulses: got %0d required %0d", n_pulse, 16 + NPOOL); end
    if (n_fe != 1) begin bad++; $display("FAIL abort_frame_end: got %0d required 1", n_fe); end
`ifdef CONV_RELU_POOL_ERR_EN
    total++;
    if (frame_err !== exp_err) begin bad++; $display("FAIL abort_err: got %b required %b", frame_err, exp_err); end
`endif
  endtask

  task automatic test_reset_mid();
    int r_cyc;
    clear_counts();
    make_img(1);
    send_frame(0, 0, 100, -1);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0;
    r_cyc = cyc;
    while (exp_q.size() > 0 && exp_q[$].cyc > r_cyc) void'(exp_q.pop_back());
    m_act = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, out_data, frame_start_out, line_start_out, frame_end_out} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got v=%b d=%0d fs=%b ls=%b fe=%b, required all 0",
               out_valid, out_data, frame_start_out, line_start_out, frame_end_out);
    end
    clear_counts();
    for (int i = 0; i < 50; i++) send(rand_acc(), 1'b0, 1'b0);
    idle(3);
    total++;
    if (n_pulse != 0) begin bad++; $display("FAIL midrst_ignored: got %0d pulses required 0", n_pulse); end
    make_img(0);
    send_frame(0, 0, NPIX, NPIX - 1);
    idle(4);
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_pending: got %0d required 0", exp_q.size()); end
    if (n_pulse != NPOOL) begin bad++; $display("FAIL midrst_pulses: got %0d required %0d", n_pulse, NPOOL); end
`ifdef CONV_RELU_POOL_ERR_EN
    total++;
    if (frame_err !== exp_err) begin bad++; $display("FAIL midrst_err: got %b required %b", frame_err, exp_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_relu_round();
    test_saturation();
    test_gapped();
    test_random();
    test_restart();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
